// File: rtl/apb_master_mux.sv
// apb_master_mux
// ---------------------------------------------------------------------------
// Single-outstanding APB master. A one-beat request (req_*) is turned into an
// APB SETUP/ACCESS transfer to one of NUM_SLAVES slaves, chosen by the address
// bits [ADDR_WIDTH-1:SEL_LSB]. Each completion produces a one-cycle rsp_valid
// pulse with a response code:
//   00 OKAY, 01 SLVERR (slave pslverr), 10 DECERR (no such slave),
//   11 TIMEOUT (slave held pready low for TIMEOUT ACCESS cycles).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  request present; held by the requester until req_ready
//   req_ready  master idle (forced low while reset is high)
//   req_write  1 = write, 0 = read
//   req_addr   byte address; upper bits select the slave
//   req_wdata  write data
//   rsp_valid  one-cycle completion pulse (no backpressure)
//   rsp_rdata  read data, zero for writes and for any error
//   rsp_code   completion code (see above)
//   paddr      registered APB address (full request address)
//   pwdata     registered APB write data
//   pwrite     registered APB direction
//   psel       one-hot slave select (at most one bit high)
//   penable    APB enable, high during ACCESS
//   pready     per-slave ready, only the selected bit is looked at
//   prdata     per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pslverr    per-slave error, only the selected bit is looked at
// ---------------------------------------------------------------------------
module apb_master_mux #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_LSB    = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_code,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic                             pwrite,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  // Width of the slave index field taken from the address.
  localparam int IDX_W = ADDR_WIDTH - SEL_LSB;
  // One extra bit so NUM_SLAVES = 2^IDX_W is representable for the range check.
  localparam logic [IDX_W:0] NUM_S = (IDX_W + 1)'(NUM_SLAVES);
  // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] CODE_OKAY    = 2'b00;
  localparam logic [1:0] CODE_SLVERR  = 2'b01;
  localparam logic [1:0] CODE_DECERR  = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DECERR
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [IDX_W-1:0]        req_idx;
  logic [IDX_W-1:0]        sel_idx;
  logic                    idx_in_range;
  logic                    accept;
  logic [CNT_W-1:0]        tmo_cnt;
  logic                    timeout_hit;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  assign req_idx      = req_addr[ADDR_WIDTH-1:SEL_LSB];
  assign idx_in_range = ({1'b0, req_idx} < NUM_S);
  assign accept       = req_valid && req_ready;
  // A slave that raises pready in the expiring cycle still wins, because the
  // next-state and response logic test sel_ready before timeout_hit.
  assign timeout_hit  = (TIMEOUT != 0) && (tmo_cnt == CNT_LAST);

  // Pick the selected slave's ready/error/data out of the per-slave vectors.
  // Signals from every other slave are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Out-of-range indices skip the APB bus entirely and
  // report DECERR one cycle later.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = idx_in_range ? ST_SETUP : ST_DECERR;
        end
      end
      ST_SETUP: begin
        next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready || timeout_hit) begin
          next_state = ST_IDLE;
        end
      end
      ST_DECERR: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state. psel is built from the latched index, which is
  // always in range whenever SETUP or ACCESS is active, so it is one-hot there
  // and all-zero elsewhere.
  always_comb begin
    req_ready = (state == ST_IDLE) && !reset;
    penable   = (state == ST_ACCESS);
    psel      = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel[i] = ((state == ST_SETUP) || (state == ST_ACCESS)) &&
                (sel_idx == IDX_W'(i));
    end
  end

  // Request capture. The APB address/data/direction are loaded only on accept
  // so they stay stable through SETUP and ACCESS and keep their last value
  // while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
      sel_idx <= '0;
    end else if (accept) begin
      paddr   <= req_addr;
      pwdata  <= req_wdata;
      pwrite  <= req_write;
      sel_idx <= req_idx;
    end
  end

  // ACCESS wait counter: cleared in SETUP, advanced on every ACCESS cycle that
  // neither completes nor times out.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == ST_SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ST_ACCESS) && !sel_ready && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Response register. rsp_valid pulses for one cycle on the edge that returns
  // the FSM to IDLE; rsp_rdata/rsp_code hold until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_code  <= CODE_OKAY;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_ACCESS: begin
          if (sel_ready) begin
            rsp_valid <= 1'b1;
            rsp_code  <= sel_err ? CODE_SLVERR : CODE_OKAY;
            rsp_rdata <= (!pwrite && !sel_err) ? sel_rdata : '0;
          end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_code  <= CODE_TIMEOUT;
            rsp_rdata <= '0;
          end
        end
        ST_DECERR: begin
          rsp_valid <= 1'b1;
          rsp_code  <= CODE_DECERR;
          rsp_rdata <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
